// File: rtl/lzy_ssd_rx.sv
// Receive-side decoder for a multiplexed 4-digit seven-segment scan bus.
// Debounces each digit dwell, decodes the glyph to hex and tracks frame validity.
module lzy_ssd_rx #(
   parameter int STABLE_CYCLES  = 2,
   parameter int TIMEOUT        = 1024,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int DG_ACTIVE_LOW  = 0
) (
   input  logic       Clk,
   input  logic       Aclr,
   input  logic [7:0] seg,
   input  logic [1:4] DG,
   output logic [3:0] A,
   output logic [3:0] B,
   output logic [3:0] C,
   output logic [3:0] D,
   output logic [1:4] DP,
   output logic       Valid,
   output logic       Upd,
   output logic       Err
);

   localparam int RW = $clog2(STABLE_CYCLES + 1) + 1;
   localparam int TW = $clog2(TIMEOUT + 1) + 1;
   localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES);
   localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);

   logic [7:0]  seg_n;
   logic [3:0]  dg_n;
   logic        eligible;
   logic        new_pair;
   logic [1:0]  pos;

   logic [11:0] samp_q;
   logic [RW-1:0] run_q, run_d;
   logic        fire;

   logic        s1_vld_q;
   logic [7:0]  s1_seg_q;
   logic [1:0]  s1_pos_q;

   logic        s2_vld_q, s2_ok_q, s2_dp_q;
   logic [3:0]  s2_val_q;
   logic [1:0]  s2_pos_q;
   logic [4:0]  dec;

   logic [3:0][3:0] val_q, val_d;
   logic [3:0]  dp_q, dp_d;
   logic [3:0]  seen_q, seen_d;
   logic [TW-1:0] to_q, to_d;
   logic        valid_q, valid_d, upd_q, upd_d, err_q, err_d;

   // {ok, value}; ok=0 for any glyph outside the hex set
   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'h3F:   return 5'h10;
         7'h06:   return 5'h11;
         7'h5B:   return 5'h12;
         7'h4F:   return 5'h13;
         7'h66:   return 5'h14;
         7'h6D:   return 5'h15;
         7'h7D:   return 5'h16;
         7'h07:   return 5'h17;
         7'h7F:   return 5'h18;
         7'h6F:   return 5'h19;
         7'h77:   return 5'h1A;
         7'h7C:   return 5'h1B;
         7'h39:   return 5'h1C;
         7'h5E:   return 5'h1D;
         7'h79:   return 5'h1E;
         7'h71:   return 5'h1F;
         default: return 5'h00;
      endcase
   endfunction

   // dg_n[3] is the leftmost digit (DG[1])
   always_comb begin
      seg_n    = (SEG_ACTIVE_LOW != 0) ? ~seg : seg;
      dg_n     = (DG_ACTIVE_LOW != 0) ? ~DG : DG;
      eligible = (dg_n != 4'd0) && ((dg_n & (dg_n - 4'd1)) == 4'd0) && (seg_n[6:0] != 7'd0);
      new_pair = ({seg_n, dg_n} != samp_q);
      case (dg_n)
         4'b1000: pos = 2'd0;
         4'b0100: pos = 2'd1;
         4'b0010: pos = 2'd2;
         default: pos = 2'd3;
      endcase
      if (!eligible)
         run_d = '0;
      else if (new_pair)
         run_d = RW'(1);
      else if (run_q == RUN_MAX)
         run_d = RUN_MAX;
      else
         run_d = run_q + RW'(1);
      // once per dwell: only on the edge the run length first reaches the target
      fire = eligible && (run_d == RUN_MAX) && (new_pair || (run_q != RUN_MAX));
      dec  = decode(s1_seg_q[6:0]);
   end

   always_comb begin
      val_d  = val_q;
      dp_d   = dp_q;
      seen_d = seen_q;
      upd_d  = 1'b0;
      err_d  = 1'b0;
      to_d   = (to_q == TO_MAX) ? to_q : to_q + TW'(1);
      if (s2_vld_q) begin
         if (s2_ok_q) begin
            upd_d            = (val_q[s2_pos_q] != s2_val_q) || (dp_q[s2_pos_q] != s2_dp_q);
            val_d[s2_pos_q]  = s2_val_q;
            dp_d[s2_pos_q]   = s2_dp_q;
            seen_d[s2_pos_q] = 1'b1;
            to_d             = '0;
         end else begin
            err_d = 1'b1;
         end
      end
      if (to_d == TO_MAX)
         seen_d = '0;
      valid_d = &seen_d;
   end

   always_ff @(posedge Clk or negedge Aclr) begin
      if (!Aclr) begin
         samp_q   <= '0;
         run_q    <= '0;
         s1_vld_q <= 1'b0;
         s1_seg_q <= '0;
         s1_pos_q <= '0;
         s2_vld_q <= 1'b0;
         s2_ok_q  <= 1'b0;
         s2_dp_q  <= 1'b0;
         s2_val_q <= '0;
         s2_pos_q <= '0;
         val_q    <= '0;
         dp_q     <= '0;
         seen_q   <= '0;
         to_q     <= '0;
         valid_q  <= 1'b0;
         upd_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         samp_q   <= {seg_n, dg_n};
         run_q    <= run_d;
         s1_vld_q <= fire;
         s1_seg_q <= seg_n;
         s1_pos_q <= pos;
         s2_vld_q <= s1_vld_q;
         s2_ok_q  <= dec[4];
         s2_val_q <= dec[3:0];
         s2_dp_q  <= s1_seg_q[7];
         s2_pos_q <= s1_pos_q;
         val_q    <= val_d;
         dp_q     <= dp_d;
         seen_q   <= seen_d;
         to_q     <= to_d;
         valid_q  <= valid_d;
         upd_q    <= upd_d;
         err_q    <= err_d;
      end
   end

   assign A     = val_q[0];
   assign B     = val_q[1];
   assign C     = val_q[2];
   assign D     = val_q[3];
   assign DP    = {dp_q[0], dp_q[1], dp_q[2], dp_q[3]};
   assign Valid = valid_q;
   assign Upd   = upd_q;
   assign Err   = err_q;

endmodule

// File: tb/tb_lzy_ssd_rx.sv
// Directed bench for lzy_ssd_rx: reset, frame decode, gaps, invalid glyphs,
// scan-loss timeout and mid-dwell reset.
module tb_lzy_ssd_rx;

   localparam int TIMEOUT = 1024;

   logic       Clk = 1'b0;
   logic       Aclr = 1'b0;
   logic [7:0] seg = 8'h00;
   logic [1:4] DG = 4'b0000;
   logic [3:0] A, B, C, D;
   logic [1:4] DP;
   logic       Valid, Upd, Err;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int upd_cnt = 0;
   int err_cnt = 0;
   int last_upd = 0;
   int fall_cyc = -1;

   lzy_ssd_rx #(
      .STABLE_CYCLES(2), .TIMEOUT(TIMEOUT), .SEG_ACTIVE_LOW(0), .DG_ACTIVE_LOW(0)
   ) dut (
      .Clk(Clk), .Aclr(Aclr), .seg(seg), .DG(DG),
      .A(A), .B(B), .C(C), .D(D), .DP(DP),
      .Valid(Valid), .Upd(Upd), .Err(Err)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
      cyc++;
      if (Upd === 1'b1) begin
         upd_cnt++;
         last_upd = cyc;
      end
      if (Err === 1'b1) err_cnt++;
      chk("upd_err_exclusive", {31'd0, Upd & Err}, 32'd0);
   endtask

   task automatic hold(input logic [1:4] dg, input logic [7:0] s, input int n);
      DG  = dg;
      seg = s;
      repeat (n) tick();
      $display("hold DG=%b seg=%h cycles=%0d -> A=%h B=%h C=%h D=%h DP=%b Valid=%b",
               dg, s, n, A, B, C, D, DP, Valid);
   endtask

   initial begin
      // reset held with random bus activity
      for (int i = 0; i < 20; i++) begin
         seg = 8'($urandom);
         DG  = 4'($urandom);
         tick();
         chk("reset_state", {16'd0, A, B, C, D, DP, Valid, Upd, Err, 1'b0}, 32'd0);
      end
      DG  = 4'b0000;
      seg = 8'h00;
      #3 Aclr = 1'b1;
      repeat (3) tick();
      chk("post_reset_outputs", {9'd0, A, B, C, D, DP, Valid, Upd, Err}, 32'd0);

      // frame decode; Valid must rise on the 4th edge of D's dwell
      upd_cnt = 0; err_cnt = 0;
      hold(4'b1000, 8'h6F, 8);
      hold(4'b0100, 8'h3F, 8);
      hold(4'b0010, 8'h66, 8);
      DG = 4'b0001; seg = 8'h7F;
      tick(); chk("valid_e1", {31'd0, Valid}, 32'd0);
      tick(); chk("valid_e2", {31'd0, Valid}, 32'd0);
      tick(); chk("valid_e3", {31'd0, Valid}, 32'd0);
      tick(); chk("valid_e4", {31'd0, Valid}, 32'd1);
      chk("d_at_capture", {28'd0, D}, 32'h8);
      hold(4'b0001, 8'h7F, 4);
      chk("frame_digits", {16'd0, A, B, C, D}, 32'h9048);
      chk("frame_dp", {28'd0, DP}, 32'h0);
      chk("frame_upd_count", upd_cnt, 3);
      chk("frame_err_count", err_cnt, 0);

      // short dwell and multi-hot select are both ignored
      upd_cnt = 0; err_cnt = 0;
      hold(4'b0100, 8'h06, 1);
      hold(4'b0000, 8'h06, 6);
      chk("glitch_b", {28'd0, B}, 32'h0);
      chk("glitch_upd", upd_cnt, 0);
      hold(4'b1100, 8'h06, 8);
      hold(4'b0000, 8'h00, 2);
      chk("multihot_digits", {16'd0, A, B, C, D}, 32'h9048);
      chk("multihot_upd", upd_cnt, 0);
      chk("multihot_err", err_cnt, 0);

      // unrecognised glyph, then the same digit with dp lit
      hold(4'b0010, 8'h49, 8);
      chk("invalid_err_count", err_cnt, 1);
      chk("invalid_upd_count", upd_cnt, 0);
      chk("invalid_c_hold", {28'd0, C}, 32'h4);
      chk("invalid_valid", {31'd0, Valid}, 32'd1);
      err_cnt = 0;
      hold(4'b0010, 8'hE6, 8);
      chk("dp_upd_count", upd_cnt, 1);
      chk("dp_err_count", err_cnt, 0);
      chk("dp_vector", {28'd0, DP}, 32'b0010);
      chk("dp_c_value", {28'd0, C}, 32'h4);

      // scan loss: Valid drops TIMEOUT cycles after the last capture
      DG = 4'b0000; seg = 8'h00;
      for (int i = 0; i < TIMEOUT + 20; i++) begin
         tick();
         if (Valid === 1'b0) begin
            fall_cyc = cyc;
            break;
         end
      end
      chk("timeout_fell", {31'd0, fall_cyc >= 0}, 32'd1);
      chk("timeout_delay", fall_cyc - last_upd, TIMEOUT);
      chk("timeout_digits", {16'd0, A, B, C, D}, 32'h9048);
      chk("timeout_dp", {28'd0, DP}, 32'b0010);

      // rescan restores Valid; only C's dp changes
      upd_cnt = 0;
      hold(4'b1000, 8'h6F, 8);
      hold(4'b0100, 8'h3F, 8);
      hold(4'b0010, 8'h66, 8);
      chk("rescan_not_yet_valid", {31'd0, Valid}, 32'd0);
      hold(4'b0001, 8'h7F, 8);
      chk("rescan_valid", {31'd0, Valid}, 32'd1);
      chk("rescan_digits", {16'd0, A, B, C, D}, 32'h9048);
      chk("rescan_dp", {28'd0, DP}, 32'h0);
      chk("rescan_upd_count", upd_cnt, 1);

      // clear during the second cycle of a dwell
      DG = 4'b1000; seg = 8'h06;
      tick();
      #2 Aclr = 1'b0;
      #1 chk("async_clear", {9'd0, A, B, C, D, DP, Valid, Upd, Err}, 32'd0);
      #2 Aclr = 1'b1;
      DG = 4'b0000; seg = 8'h00;
      upd_cnt = 0;
      hold(4'b0000, 8'h00, 2);
      hold(4'b0100, 8'h06, 1);
      hold(4'b0000, 8'h00, 6);
      chk("after_clear_1cyc_b", {28'd0, B}, 32'h0);
      chk("after_clear_1cyc_upd", upd_cnt, 0);
      hold(4'b0100, 8'h06, 2);
      hold(4'b0000, 8'h00, 6);
      chk("after_clear_2cyc_b", {28'd0, B}, 32'h1);
      chk("after_clear_2cyc_upd", upd_cnt, 1);
      chk("after_clear_a", {28'd0, A}, 32'h0);
      chk("after_clear_valid", {31'd0, Valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
